// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state encoding and default latency.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_e;

    localparam int DEF_MEM_LAT = 4;
    localparam int DEF_CNT_W   = 3;

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// Latency counter: counts memory cycles of a grant and flags the final (MEM_LAT-th) cycle.
module lat_counter
    import mem_arbiter_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = en && (cnt_q == CNT_W'(MEM_LAT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one fixed-latency unified memory between instruction fetch (I) and data LW/SW (D).
// Each grant runs MEM_LAT memory cycles, then returns a registered one-cycle done pulse with read data.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = DEF_MEM_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              cancel_q, cancel_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic              busy;
    logic              last_cyc;

    assign busy = (state_q != ARB_IDLE);

    lat_counter #(
        .CNT_W  (CNT_W),
        .MEM_LAT(MEM_LAT)
    ) u_lat (
        .clk(clk),
        .rst(rst),
        .clr(~busy),
        .en (busy),
        .tc (last_cyc)
    );

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        cancel_d  = cancel_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                // D wins ties unless it took the previous grant while I was waiting
                if (d_req && !(last_d_q && i_req)) begin
                    state_d  = ARB_GNT_D;
                    last_d_d = 1'b1;
                    wr_d     = d_wr;
                    addr_d   = d_addr;
                    wdata_d  = d_wdata;
                end else if (i_req) begin
                    state_d  = ARB_GNT_I;
                    last_d_d = 1'b0;
                    wr_d     = 1'b0;
                    addr_d   = i_addr;
                    wdata_d  = '0;
                end
            end
            ARB_GNT_I: begin
                // A dropped fetch is a flush: the access finishes but its result is discarded
                if (!i_req) begin
                    cancel_d = 1'b1;
                end
                if (last_cyc) begin
                    state_d  = ARB_IDLE;
                    cancel_d = 1'b0;
                    if (i_req && !cancel_q) begin
                        i_done_d  = 1'b1;
                        i_rdata_d = mem_rdata;
                    end
                end
            end
            ARB_GNT_D: begin
                if (last_cyc) begin
                    state_d  = ARB_IDLE;
                    d_done_d = 1'b1;
                    if (!wr_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            last_d_q  <= 1'b0;
            cancel_q  <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            cancel_q  <= cancel_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
        end
    end

    assign i_rdata   = i_rdata_q;
    assign i_done    = i_done_q;
    assign i_stall   = i_req & ~i_done_q;
    assign d_rdata   = d_rdata_q;
    assign d_done    = d_done_q;
    assign d_stall   = d_req & ~d_done_q;
    assign mem_en    = busy;
    assign mem_wr    = (state_q == ARB_GNT_D) & wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule
